// File: rtl/id_ex_forward_stage.sv
// ID/EX pipeline register with operand-forwarding select generation,
// load-use stall detection and a saturating bubble counter.
//
// Forward select encoding (operand mux in EX):
//   00 = register-file value captured in ID/EX
//   01 = EX/MEM ALU result
//   10 = MEM/WB write-back data
// 11 is never produced.
module id_ex_forward_stage #(
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,

  // Decoded instruction from ID
  input  logic              id_valid,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic              id_uses_rt,
  input  logic [31:0]       id_rs_data,
  input  logic [31:0]       id_rt_data,
  input  logic [31:0]       id_imm,
  input  logic              id_mem_read,
  input  logic              id_reg_write,
  input  logic [CTRL_W-1:0] id_ctrl,

  // Squash the instruction entering EX
  input  logic              flush,

  // Later-stage destination info
  input  logic              exmem_reg_write,
  input  logic [4:0]        exmem_rd,
  input  logic              memwb_reg_write,
  input  logic [4:0]        memwb_rd,
  input  logic [31:0]       memwb_data,

  // Registered EX-stage view
  output logic              ex_valid,
  output logic              ex_mem_read,
  output logic              ex_reg_write,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [31:0]       ex_rs_data,
  output logic [31:0]       ex_rt_data,
  output logic [31:0]       ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,

  // Operand mux selects, stall and bubble statistics
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              stall,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [1:0] SEL_RF    = 2'b00;
  localparam logic [1:0] SEL_EXMEM = 2'b01;
  localparam logic [1:0] SEL_MEMWB = 2'b10;

  logic        load_bubble;
  logic        wb_hit_rs;
  logic        wb_hit_rt;
  logic [31:0] rs_data_byp;
  logic [31:0] rt_data_byp;
  logic        cnt_sat;

  // Load-use hazard: the load in EX has not produced its data yet, so ID must wait a cycle.
  always_comb begin
    stall = ex_valid & ex_mem_read & (ex_rd != 5'd0) & id_valid &
            ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));
  end

  // A bubble is loaded on flush or stall; flush covers the same edge without a second bubble.
  assign load_bubble = flush | stall;

  // Write-back bypass so a same-cycle register-file write is not missed by the ID read.
  always_comb begin
    wb_hit_rs   = memwb_reg_write & (memwb_rd != 5'd0) & (memwb_rd == id_rs);
    wb_hit_rt   = memwb_reg_write & (memwb_rd != 5'd0) & (memwb_rd == id_rt);
    rs_data_byp = wb_hit_rs ? memwb_data : id_rs_data;
    rt_data_byp = wb_hit_rt ? memwb_data : id_rt_data;
  end

  // Pipeline register capture: reset > bubble > normal.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_rs        <= 5'd0;
      ex_rt        <= 5'd0;
      ex_rd        <= 5'd0;
      ex_rs_data   <= 32'd0;
      ex_rt_data   <= 32'd0;
      ex_imm       <= 32'd0;
      ex_ctrl      <= '0;
    end else if (load_bubble) begin
      ex_valid     <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_rs        <= 5'd0;
      ex_rt        <= 5'd0;
      ex_rd        <= 5'd0;
      ex_rs_data   <= 32'd0;
      ex_rt_data   <= 32'd0;
      ex_imm       <= 32'd0;
      ex_ctrl      <= '0;
    end else begin
      // Flags are qualified by id_valid so an empty slot never reads memory or writes a register.
      ex_valid     <= id_valid;
      ex_mem_read  <= id_valid & id_mem_read;
      ex_reg_write <= id_valid & id_reg_write;
      ex_rs        <= id_rs;
      ex_rt        <= id_rt;
      ex_rd        <= id_rd;
      ex_rs_data   <= rs_data_byp;
      ex_rt_data   <= rt_data_byp;
      ex_imm       <= id_imm;
      ex_ctrl      <= id_ctrl;
    end
  end

  assign cnt_sat = &bubble_cnt;

  // Count stall/flush bubbles only; saturate instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (load_bubble && !cnt_sat) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

  // Operand A select: EX/MEM wins over MEM/WB; register 0 is never forwarded.
  always_comb begin
    fwd_a_sel = SEL_RF;
    if (ex_valid && exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == ex_rs)) begin
      fwd_a_sel = SEL_EXMEM;
    end else if (ex_valid && memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == ex_rs)) begin
      fwd_a_sel = SEL_MEMWB;
    end
  end

  // Operand B select: same rule applied to rt.
  always_comb begin
    fwd_b_sel = SEL_RF;
    if (ex_valid && exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == ex_rt)) begin
      fwd_b_sel = SEL_EXMEM;
    end else if (ex_valid && memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == ex_rt)) begin
      fwd_b_sel = SEL_MEMWB;
    end
  end

endmodule
